// File: rtl/nand_exerciser_if.sv
// nand_exerciser_if
// Purpose: groups the exerciser's control/result handshake and the gate-side
//          drive/sense signals into one bundle.
// Signals:
//   start      - begin a run (accepted only while not busy)
//   a_drv      - registered drive to gate input A
//   b_drv      - registered drive to gate input B
//   y_in       - gate output fed back to the exerciser
//   busy       - run in progress
//   done       - one-cycle completion pulse
//   pass       - result of the last completed run
//   err_cnt    - saturating mismatch count
//   dbg_state  - current FSM state of the exerciser (debug visibility)
//   fail_vec   - {A,B} of the first mismatch   (NAND_EXERCISER_CAPTURE_EN only)
//   fail_valid - fail_vec holds a capture       (NAND_EXERCISER_CAPTURE_EN only)
// Modports: slave = the exerciser, master = the host plus the gate under test.
// Handshake: start is a level sampled on the rising clock edge; it is taken
//   whenever busy is low, and done pulses for exactly one cycle when the run
//   finishes, with pass/err_cnt valid from that cycle until the next start.
interface nand_exerciser_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             a_drv;
    logic             b_drv;
    logic             y_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       dbg_state;
`ifdef NAND_EXERCISER_CAPTURE_EN
    logic [1:0]       fail_vec;
    logic             fail_valid;

    modport slave (
        input  start, y_in,
        output a_drv, b_drv, busy, done, pass, err_cnt, dbg_state,
        output fail_vec, fail_valid
    );
    modport master (
        output start, y_in,
        input  a_drv, b_drv, busy, done, pass, err_cnt, dbg_state,
        input  fail_vec, fail_valid
    );
`else
    modport slave (
        input  start, y_in,
        output a_drv, b_drv, busy, done, pass, err_cnt, dbg_state
    );
    modport master (
        output start, y_in,
        input  a_drv, b_drv, busy, done, pass, err_cnt, dbg_state
    );
`endif
endinterface

// File: rtl/nand_exerciser.sv
// nand_exerciser
// Purpose: drives a 2-input NAND under test through {A,B} = 00,01,10,11,
//          REPEAT times, samples the gate output at the end of every SETTLE
//          window, counts mismatches against ~(A&B) and reports pass/fail.
// Parameters: SETTLE (1..255) hold cycles per vector, REPEAT (>=1) sweeps per
//          run, CNT_W mismatch counter width.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - nand_exerciser_if.slave (start, y_in in; drives, status, results out)
// Optional feature: define NAND_EXERCISER_CAPTURE_EN to capture the first
//          mismatching vector on bus.fail_vec / bus.fail_valid.
module nand_exerciser #(
    parameter int SETTLE = 2,
    parameter int REPEAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    nand_exerciser_if.slave   bus
);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SET_W-1:0] r_settle;
    logic [REP_W-1:0] r_sweep;
    logic [1:0]       r_ab;
    logic [CNT_W-1:0] r_err;
    logic             r_pass;
    logic             w_busy;
    logic             w_done;
    logic             w_accept;
    logic             w_tick;
    logic             w_last;
    logic             w_expect;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_err_next;

    // DONE counts as idle for start acceptance, so back-to-back runs work.
    assign w_accept   = bus.start && (r_state != S_RUN);
    // End of the settle window: sample this vector, register the next one.
    assign w_tick     = (r_state == S_RUN) && (r_settle == SET_W'(SETTLE - 1));
    assign w_last     = w_tick && (r_ab == 2'b11) && (r_sweep == REP_W'(REPEAT - 1));
    assign w_expect   = ~(r_ab[1] & r_ab[0]);
    // Case inequality so an X/Z gate output is scored as a mismatch.
    assign w_mismatch = (bus.y_in !== w_expect);
    assign w_err_next = (w_tick && w_mismatch && (r_err != {CNT_W{1'b1}}))
                        ? r_err + 1'b1 : r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = bus.start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle <= '0;
            r_sweep  <= '0;
            r_ab     <= 2'b00;
            r_err    <= '0;
            r_pass   <= 1'b0;
        end else if (w_accept) begin
            r_settle <= '0;
            r_sweep  <= '0;
            r_ab     <= 2'b00;
            r_err    <= '0;
            r_pass   <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_err <= w_err_next;
            if (w_tick) begin
                r_settle <= '0;
                // 11 wraps to 00, which is also the idle drive after the last vector.
                r_ab     <= r_ab + 2'b01;
                if (r_ab == 2'b11) r_sweep <= r_sweep + 1'b1;
                if (w_last) r_pass <= (w_err_next == '0);
            end else begin
                r_settle <= r_settle + 1'b1;
            end
        end
    end

`ifdef NAND_EXERCISER_CAPTURE_EN
    logic [1:0] r_fail_vec;
    logic       r_fail_valid;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_fail_vec   <= 2'b00;
            r_fail_valid <= 1'b0;
        end else if (w_tick && w_mismatch && !r_fail_valid) begin
            r_fail_vec   <= r_ab;
            r_fail_valid <= 1'b1;
        end
    end

    assign bus.fail_vec   = r_fail_vec;
    assign bus.fail_valid = r_fail_valid;
`endif

    assign bus.a_drv     = r_ab[1];
    assign bus.b_drv     = r_ab[0];
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.pass      = r_pass;
    assign bus.err_cnt   = r_err;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_nand_exerciser.sv
// tb_nand_exerciser
// Purpose: self-checking bench for nand_exerciser. dut0 uses SETTLE=2,
//          REPEAT=1; dut1 uses SETTLE=2, REPEAT=100 to reach err_cnt saturation.
//          Gate behaviour is selected per run by a mode variable.
module tb_nand_exerciser;
    localparam int CNT_W = 8;

    // Gate models: 0 NAND, 1 stuck-at-1, 2 stuck-at-0, 3 AND
    localparam int M_NAND = 0;
    localparam int M_ST1  = 1;
    localparam int M_ST0  = 2;
    localparam int M_AND  = 3;

    logic clk;
    logic rst;
    int   mode0;
    int   n_tests;
    int   n_fail;

    nand_exerciser_if #(.CNT_W(CNT_W)) bus0 ();
    nand_exerciser_if #(.CNT_W(CNT_W)) bus1 ();

    nand_exerciser #(.SETTLE(2), .REPEAT(1), .CNT_W(CNT_W)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    nand_exerciser #(.SETTLE(2), .REPEAT(100), .CNT_W(CNT_W)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    always_comb begin
        case (mode0)
            M_ST1:   bus0.y_in = 1'b1;
            M_ST0:   bus0.y_in = 1'b0;
            M_AND:   bus0.y_in = bus0.a_drv & bus0.b_drv;
            default: bus0.y_in = ~(bus0.a_drv & bus0.b_drv);
        endcase
    end

    // dut1 always sees an AND gate: every vector mismatches.
    assign bus1.y_in = bus1.a_drv & bus1.b_drv;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at E0+1 (start accepted at E0).
    task automatic start0();
        step();
        bus0.start = 1'b1;
        step();
        bus0.start = 1'b0;
    endtask

    task automatic wait_done0(input int budget, output int lat);
        lat = 0;
        while (!bus0.done && lat < budget) begin
            step();
            lat++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_a"},    {31'd0, bus0.a_drv}, 32'd0);
        check({tag, "_b"},    {31'd0, bus0.b_drv}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus0.busy},  32'd0);
        check({tag, "_done"}, {31'd0, bus0.done},  32'd0);
        check({tag, "_pass"}, {31'd0, bus0.pass},  32'd0);
        check({tag, "_err"},  32'(bus0.err_cnt),   32'd0);
`ifdef NAND_EXERCISER_CAPTURE_EN
        check({tag, "_fvec"}, 32'(bus0.fail_vec),     32'd0);
        check({tag, "_fval"}, {31'd0, bus0.fail_valid}, 32'd0);
`endif
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         mode;
        logic [7:0] exp_err;
        logic       exp_pass;
        logic [1:0] exp_fvec;
        logic       exp_fval;
    } run_vec_t;

    run_vec_t tbl[5];

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int lat1;
        int n_done;

        n_tests    = 0;
        n_fail     = 0;
        mode0      = M_NAND;
        rst        = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;

        tbl[0] = '{M_NAND, 8'd0, 1'b1, 2'b00, 1'b0};
        tbl[1] = '{M_ST1,  8'd1, 1'b0, 2'b11, 1'b1};
        tbl[2] = '{M_ST0,  8'd3, 1'b0, 2'b00, 1'b1};
        tbl[3] = '{M_AND,  8'd4, 1'b0, 2'b00, 1'b1};
        tbl[4] = '{M_NAND, 8'd0, 1'b1, 2'b00, 1'b0};

        repeat (3) step();
        check_reset_vals("rst_hold");
        rst = 1'b0;
        step();
        check_reset_vals("rst_rel");

        // Drive sequence of a good run: 00,01,10,11 at E0,E2,E4,E6; done at E8.
        mode0 = M_NAND;
        start0();
        check("seq_busy_e0", {31'd0, bus0.busy}, 32'd1);
        check("seq_ab_e0", {30'd0, bus0.a_drv, bus0.b_drv}, 32'd0);
        step();
        check("seq_ab_e1", {30'd0, bus0.a_drv, bus0.b_drv}, 32'd0);
        step();
        check("seq_ab_e2", {30'd0, bus0.a_drv, bus0.b_drv}, 32'd1);
        repeat (2) step();
        check("seq_ab_e4", {30'd0, bus0.a_drv, bus0.b_drv}, 32'd2);
        repeat (2) step();
        check("seq_ab_e6", {30'd0, bus0.a_drv, bus0.b_drv}, 32'd3);
        check("seq_busy_e6", {31'd0, bus0.busy}, 32'd1);
        repeat (2) step();
        check("seq_done_e8", {31'd0, bus0.done}, 32'd1);
        check("seq_busy_e8", {31'd0, bus0.busy}, 32'd0);
        check("seq_ab_e8", {30'd0, bus0.a_drv, bus0.b_drv}, 32'd0);
        check("seq_pass_e8", {31'd0, bus0.pass}, 32'd1);
        step();
        check("seq_done_e9", {31'd0, bus0.done}, 32'd0);

        // Table-driven runs over the gate models.
        for (int i = 0; i < 5; i++) begin
            mode0 = tbl[i].mode;
            start0();
            wait_done0(20, lat);
            check($sformatf("t%0d_lat", i), 32'(lat), 32'd8);
            check($sformatf("t%0d_err", i), 32'(bus0.err_cnt), 32'(tbl[i].exp_err));
            check($sformatf("t%0d_pass", i), {31'd0, bus0.pass}, {31'd0, tbl[i].exp_pass});
`ifdef NAND_EXERCISER_CAPTURE_EN
            check($sformatf("t%0d_fvec", i), 32'(bus0.fail_vec), 32'(tbl[i].exp_fvec));
            check($sformatf("t%0d_fval", i), {31'd0, bus0.fail_valid}, {31'd0, tbl[i].exp_fval});
`endif
            repeat (2) step();
            check($sformatf("t%0d_pass_hold", i), {31'd0, bus0.pass}, {31'd0, tbl[i].exp_pass});
        end

        // Reset at E3 of a run aborts it with no done pulse.
        mode0 = M_ST0;
        start0();
        repeat (2) step();
        check("abort_err_e2", 32'(bus0.err_cnt), 32'd1);
        rst = 1'b1;
        step();
        check_reset_vals("abort");
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus0.done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        mode0 = M_NAND;
        start0();
        wait_done0(20, lat);
        check("after_abort_lat", 32'(lat), 32'd8);
        check("after_abort_pass", {31'd0, bus0.pass}, 32'd1);

        // start pulsed at E1 is ignored; done still lands on E8.
        mode0 = M_ST1;
        start0();
        bus0.start = 1'b1;
        step();
        bus0.start = 1'b0;
        wait_done0(20, lat);
        check("ign_start_lat", 32'(lat), 32'd7);
        check("ign_start_err", 32'(bus0.err_cnt), 32'd1);

        // start held in the done cycle starts a new run immediately.
        mode0 = M_NAND;
        start0();
        wait_done0(20, lat);
        check("b2b_pass_first", {31'd0, bus0.pass}, 32'd1);
        bus0.start = 1'b1;
        step();
        bus0.start = 1'b0;
        check("b2b_busy", {31'd0, bus0.busy}, 32'd1);
        check("b2b_pass_clr", {31'd0, bus0.pass}, 32'd0);
        check("b2b_err_clr", 32'(bus0.err_cnt), 32'd0);
        check("b2b_ab", {30'd0, bus0.a_drv, bus0.b_drv}, 32'd0);
        wait_done0(20, lat);
        check("b2b_lat", 32'(lat), 32'd8);
        check("b2b_pass_second", {31'd0, bus0.pass}, 32'd1);

        // Saturation: AND gate, 400 mismatches clamp at 255; latency 800.
        step();
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        lat1 = 0;
        while (!bus1.done && lat1 < 1000) begin
            step();
            lat1++;
        end
        check("sat_lat", 32'(lat1), 32'd800);
        check("sat_err", 32'(bus1.err_cnt), 32'd255);
        check("sat_pass", {31'd0, bus1.pass}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
